// File: rtl/bmm150_pkg.sv
// Shared types and constants for the BMM150 SPI responder model.
package bmm150_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    DONE
  } state_t;

  localparam logic [6:0] BMM150_CHIP_ID_ADDR = 7'h40;
  localparam logic [7:0] BMM150_CHIP_ID      = 8'h32;
  localparam logic       SPI_RW_READ         = 1'b1;
  localparam int         FRAME_BITS          = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous SPI pin, with a third flop
// for edge detection. Outputs the synchronized level plus one-clk
// rise and fall pulses.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  // Synchronizer chain plus a delayed copy for edge detection.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      s3 <= RST_VAL;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/spi_slave_bmm150_model.sv
// SPI mode-3 responder emulating the BMM150 register interface.
// Frames: RW bit, 7-bit address, 8-bit data, all MSB first.
// Optional build macro SPI_SLAVE_BMM150_BURST_EN: after each data byte the
// frame continues with address+1 instead of ignoring further clocks.
module spi_slave_bmm150_model
  import bmm150_pkg::*;
#(
  parameter logic [6:0] ADDR_BASE = BMM150_CHIP_ID_ADDR,
  parameter int         REG_COUNT = 50,
  parameter logic [7:0] CHIP_ID   = BMM150_CHIP_ID
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic       ld_en,
  input  logic [6:0] ld_addr,
  input  logic [7:0] ld_data,
  output logic       wr_valid,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .din(cs_n),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .din(mosi),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  // Only the sclk edges and the mosi level matter to the protocol.
  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, mosi_rise, mosi_fall};

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       rw_q;
  logic [6:0] addr_q;
  logic [7:0] snap;
  logic [7:0] regs [REG_COUNT];

  function automatic logic in_window(input logic [6:0] a);
    return (int'(a) >= int'(ADDR_BASE)) && (int'(a) < int'(ADDR_BASE) + REG_COUNT);
  endfunction

  // The CHIP_ID location is read-only; everything else in the window is RW.
  function automatic logic writable(input logic [6:0] a);
    return in_window(a) && (a != ADDR_BASE);
  endfunction

  function automatic logic [7:0] read_reg(input logic [6:0] a);
    logic [7:0] r;
    r = 8'h00;
    if (a == ADDR_BASE) begin
      r = CHIP_ID;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (int'(a) == int'(ADDR_BASE) + i) r = regs[i];
      end
    end
    return r;
  endfunction

  logic [7:0] rx_byte;
  logic       last_rise;
  logic       abort;
  logic       commit;

  assign rx_byte   = {shreg[6:0], mosi_lvl};
  assign last_rise = sclk_rise && (bit_cnt == LAST_BIT);
  assign abort     = !enable || cs_rise;
  assign commit    = (state == DATA) && last_rise && !abort && (rw_q != SPI_RW_READ);
  assign busy      = ~cs_lvl & enable;

  // Register file: SPI commits take priority over the local load port.
  // NOTE: the array is reset because the emulated registers must read 0x00
  // after reset; that makes it plain flops rather than an inferred RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= 8'h00;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (commit && writable(addr_q) && (int'(addr_q) == int'(ADDR_BASE) + i)) begin
          regs[i] <= rx_byte;
        end else if (ld_en && writable(ld_addr) && (int'(ld_addr) == int'(ADDR_BASE) + i)) begin
          regs[i] <= ld_data;
        end
      end
    end
  end

  // Frame FSM: command decode, read shift-out, write commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      shreg    <= 8'h00;
      rw_q     <= 1'b0;
      addr_q   <= 7'h00;
      snap     <= 8'h00;
      miso     <= 1'b1;
      miso_oe  <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= 7'h00;
      wr_data  <= 8'h00;
    end else begin
      wr_valid <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        miso    <= 1'b1;
        miso_oe <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state   <= CMD;
              bit_cnt <= 3'd0;
              miso    <= 1'b1;
              miso_oe <= 1'b1;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (last_rise) begin
                rw_q    <= rx_byte[7];
                addr_q  <= rx_byte[6:0];
                snap    <= read_reg(rx_byte[6:0]);
                bit_cnt <= 3'd0;
                state   <= DATA;
              end
            end
          end
          DATA: begin
            if (sclk_fall && (rw_q == SPI_RW_READ)) begin
              miso <= snap[7];
              snap <= {snap[6:0], 1'b0};
            end
            if (sclk_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (last_rise) begin
                if (rw_q != SPI_RW_READ) begin
                  wr_valid <= 1'b1;
                  wr_addr  <= addr_q;
                  wr_data  <= rx_byte;
                end
                bit_cnt <= 3'd0;
`ifdef SPI_SLAVE_BMM150_BURST_EN
                addr_q <= addr_q + 7'd1;
                snap   <= read_reg(addr_q + 7'd1);
`else
                state <= DONE;
                miso  <= 1'b1;
`endif
              end
            end
          end
          DONE: begin
            miso <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_bmm150_model.sv
// Self-checking bench for spi_slave_bmm150_model. Expected read bytes and
// expected write commits are queued when a frame is driven and compared when
// the model returns data or pulses wr_valid.
module tb_spi_slave_bmm150_model;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic       sclk = 1'b1;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b1;
  logic       miso;
  logic       miso_oe;
  logic       ld_en = 1'b0;
  logic [6:0] ld_addr = 7'h00;
  logic [7:0] ld_data = 8'h00;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  spi_slave_bmm150_model dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0]  model [128];
  logic [7:0]  rd_q [$];
  logic [14:0] wr_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_read(input logic [6:0] a);
    if (a == 7'h40) return 8'h32;
    if (a > 7'h40 && a <= 7'h71) return model[a];
    return 8'h00;
  endfunction

  function automatic logic is_writable(input logic [6:0] a);
    return (a > 7'h40) && (a <= 7'h71);
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode 3: drive on the falling sclk edge, sample miso on the rising edge.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, input bit collide,
                          output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0;
      mosi = tx[7-i];
      wait_clk(5);
      sclk = 1'b1;
      rx[7-i] = miso;
      if (collide && i == 7) begin
        // Land ld_en on the clock where the synchronized 8th rise commits.
        wait_clk(2);
        ld_en = 1'b1;
        wait_clk(1);
        ld_en = 1'b0;
        wait_clk(2);
      end else begin
        wait_clk(5);
      end
    end
  endtask

  task automatic spi_start();
    cs_n = 1'b0;
    wait_clk(6);
  endtask

  task automatic spi_stop();
    cs_n = 1'b1;
    mosi = 1'b1;
    wait_clk(10);
  endtask

  task automatic local_load(input logic [6:0] a, input logic [7:0] d);
    ld_addr = a;
    ld_data = d;
    ld_en   = 1'b1;
    wait_clk(1);
    ld_en   = 1'b0;
    if (is_writable(a)) model[a] = d;
  endtask

  task automatic spi_read(input logic [6:0] a, input int nbytes);
    logic [7:0] rx;
    logic [7:0] exp;
    for (int k = 0; k < nbytes; k++) begin
`ifdef SPI_SLAVE_BMM150_BURST_EN
      exp = exp_read(7'(a + 7'(k)));
`else
      exp = (k == 0) ? exp_read(a) : 8'hFF;
`endif
      if (!enable) exp = 8'hFF;
      rd_q.push_back(exp);
    end
    spi_start();
    check($sformatf("busy_rd_%02h", a), 32'(busy), 32'(enable));
    check($sformatf("oe_rd_%02h", a), 32'(miso_oe), 32'(enable));
    spi_bits({1'b1, a}, 8, 1'b0, rx);
    check($sformatf("cmd_miso_%02h", a), 32'(rx), 32'hFF);
    for (int k = 0; k < nbytes; k++) begin
      spi_bits(8'h00, 8, 1'b0, rx);
      check($sformatf("rd_%02h_b%0d", a, k), 32'(rx), 32'(rd_q.pop_front()));
    end
    spi_stop();
    check($sformatf("idle_oe_%02h", a), 32'(miso_oe), 32'h0);
  endtask

  task automatic spi_write(input logic [6:0] a, input logic [7:0] d,
                           input int data_bits, input bit collide);
    logic [7:0] rx;
    if (data_bits == 8) begin
      wr_q.push_back({a, d});
      if (is_writable(a)) model[a] = d;
    end
    spi_start();
    spi_bits({1'b0, a}, 8, 1'b0, rx);
    spi_bits(d, data_bits, collide, rx);
    check($sformatf("wr_miso_%02h", a), 32'(miso), 32'h1);
    spi_stop();
    check($sformatf("wr_commit_%02h", a), 32'(wr_q.size()), 32'h0);
  endtask

  // Write monitor: every wr_valid cycle must match the next queued commit.
  always @(negedge clk) begin
    if (rst_n && wr_valid) begin
      check("wr_expected", 32'(wr_q.size() != 0), 32'h1);
      if (wr_q.size() != 0) begin
        logic [14:0] e;
        e = wr_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e[14:8]));
        check("wr_data", 32'(wr_data), 32'(e[7:0]));
      end
    end
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) model[i] = 8'h00;

    // Reset values.
    wait_clk(3);
    check("rst_miso", 32'(miso), 32'h1);
    check("rst_miso_oe", 32'(miso_oe), 32'h0);
    check("rst_wr_valid", 32'(wr_valid), 32'h0);
    check("rst_wr_addr", 32'(wr_addr), 32'h0);
    check("rst_wr_data", 32'(wr_data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    wait_clk(5);

    // CHIP_ID read.
    spi_read(7'h40, 1);

    // Write then read back.
    spi_write(7'h4B, 8'h01, 8, 1'b0);
    spi_read(7'h4B, 1);

    // Write to CHIP_ID is reported but not stored; out-of-window reads 0.
    spi_write(7'h40, 8'hFF, 8, 1'b0);
    spi_read(7'h40, 1);
    spi_read(7'h10, 1);

    // Aborted frame after 12 bits commits nothing.
    spi_write(7'h4C, 8'h5A, 4, 1'b0);
    spi_read(7'h4C, 1);
    spi_read(7'h4B, 1);

    // Local load, including ignored targets and the last window register.
    local_load(7'h42, 8'hA5);
    spi_read(7'h42, 1);
    local_load(7'h40, 8'h99);
    local_load(7'h72, 8'h77);
    local_load(7'h71, 8'h6C);
    spi_read(7'h40, 1);
    spi_read(7'h72, 1);
    spi_read(7'h71, 1);

    // Same-clock SPI commit and local load: SPI wins.
    ld_addr = 7'h42;
    ld_data = 8'h22;
    spi_write(7'h42, 8'h11, 8, 1'b1);
    spi_read(7'h42, 1);

    // Multi-byte read: burst or trailing 0xFF depending on build.
    local_load(7'h42, 8'h01);
    local_load(7'h43, 8'h02);
    local_load(7'h44, 8'h03);
    spi_read(7'h42, 3);

    // Disabled: bus ignored, no output enable, no busy.
    enable = 1'b0;
    spi_read(7'h4B, 1);
    enable = 1'b1;
    wait_clk(5);
    spi_read(7'h4B, 1);

    check("wr_q_drained", 32'(wr_q.size()), 32'h0);
    check("rd_q_drained", 32'(rd_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
